// File: rtl/vending_machine_if.sv
// Coin-acceptor / dispense-actuator bundle for the soda vending controller.
// The coin acceptor is the master (drives strobes); the controller is the slave.
interface vending_machine_if;
  logic       nickle;
  logic       dime;
  logic       quarter;
  logic       soda;
  logic [2:0] change;

  modport master (
    output nickle,
    output dime,
    output quarter,
    input  soda,
    input  change
  );

  modport slave (
    input  nickle,
    input  dime,
    input  quarter,
    output soda,
    output change
  );
endinterface : vending_machine_if

// File: rtl/vending_machine.sv
// Single-product soda vending controller.
// Accumulates coin credit in nickels and, once credit reaches PRICE, issues a
// one-cycle soda strobe together with the refund (in nickels). Excess credit
// is always refunded, never carried into the next vend.
//
// Build option: define VENDING_MACHINE_COIN_EDGE_EN to count each coin strobe
// once per rising edge of the input. Without it, every clock edge on which a
// strobe is high counts one coin.
//
// PRICE legal range is 1..15 nickels.
module vending_machine #(
  parameter int unsigned PRICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  vending_machine_if.slave coin_if
);

  // Credit register doubles as the FSM state: Cn holds n nickels of credit.
  typedef enum logic [3:0] {
    C0, C1, C2,  C3,  C4,  C5,  C6,  C7,
    C8, C9, C10, C11, C12, C13, C14, C15
  } credit_e;

  localparam logic [4:0] PRICE_W = 5'(PRICE);

  credit_e    credit_q, credit_d;
  logic       soda_q,   soda_d;
  logic [2:0] change_q, change_d;

  logic [2:0] coins;     // {quarter, dime, nickle}
  logic [2:0] coin_hit;  // coins that count on this edge
  logic [3:0] ins;       // coin value this edge, max 8
  logic [4:0] total;     // credit + ins, max 22

  assign coins = {coin_if.quarter, coin_if.dime, coin_if.nickle};

`ifdef VENDING_MACHINE_COIN_EDGE_EN
  logic [2:0] coin_prev_q;

  // Previous-sample history for the per-input rising-edge detectors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) coin_prev_q <= '0;
    else          coin_prev_q <= coins;
  end

  assign coin_hit = coins & ~coin_prev_q;
`else
  assign coin_hit = coins;
`endif

  // Sum simultaneous strobes, then decide between vend and accumulate.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    credit_d = credit_q;
    soda_d   = 1'b0;
    change_d = 3'd0;

    ins   = {3'b000, coin_hit[0]}
          + {2'b00, coin_hit[1], 1'b0}
          + (coin_hit[2] ? 4'd5 : 4'd0);
    total = {1'b0, credit_q} + {1'b0, ins};

    if (total >= PRICE_W) begin
      // Vend: refund is at most (PRICE-1)+8-PRICE = 7, so 3 bits suffice.
      soda_d   = 1'b1;
      change_d = 3'(total - PRICE_W);
      credit_d = C0;
    end else begin
      // total < PRICE <= 15, so it always fits the 4-bit credit register.
      credit_d = credit_e'(total[3:0]);
    end
  end

  // Credit state and registered dispense outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      credit_q <= C0;
      soda_q   <= 1'b0;
      change_q <= 3'd0;
    end else begin
      credit_q <= credit_d;
      soda_q   <= soda_d;
      change_q <= change_d;
    end
  end

  assign coin_if.soda   = soda_q;
  assign coin_if.change = change_q;

endmodule : vending_machine

// File: tb/tb_vending_machine.sv
// Directed, table-driven bench for vending_machine with PRICE = 4.
// Table rows are chosen so that single-cycle strobes behave identically in
// both coin-sampling builds; held-strobe cases are hand-written per build.
module tb_vending_machine;

  logic clk;
  logic reset_n;

  int n_vec;
  int n_miss;

  vending_machine_if vif ();

  vending_machine #(.PRICE(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .coin_if (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       n;
    logic       d;
    logic       q;
    logic       exp_soda;
    logic [2:0] exp_change;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic exp_soda,
                       input logic [2:0] exp_change);
    n_vec++;
    if (vif.soda !== exp_soda || vif.change !== exp_change) begin
      n_miss++;
      $display("FAIL %s: got soda=%b change=%0d, want soda=%b change=%0d",
               name, vif.soda, vif.change, exp_soda, exp_change);
    end
  endtask

  task automatic drive(input logic n, input logic d, input logic q);
    vif.nickle  = n;
    vif.dime    = d;
    vif.quarter = q;
  endtask

  // Present coins for one edge, then sample 1 time unit after that edge.
  task automatic step(input string name, input logic n, input logic d,
                      input logic q, input logic exp_soda,
                      input logic [2:0] exp_change);
    drive(n, d, q);
    @(posedge clk);
    #1;
    check(name, exp_soda, exp_change);
  endtask

  task automatic pulse_reset();
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    //            n     d     q     soda  chg      credit after
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0};  // 2
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd3};  // 2+5=7 -> vend, 0
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};  // coin during soda: 1
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0};  // 3
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd4};  // 3+5=8 -> vend, 0
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0};  // 3
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};  // holds 3
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd7};  // 3+8=11 -> vend 7
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};  // 0
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1};  // 5 -> vend 1
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};  // 0
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};  // 1
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};  // 1
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};  // 2
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};  // 2
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};  // 3
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};  // 3
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0};  // 4 -> vend 0
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0};  // 0

    // Reset held with coins toggling: outputs stay 0 throughout.
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    for (int i = 0; i < 6; i++) begin
      drive(i[0], i[1], ~i[0]);
      @(posedge clk);
      #1;
      check($sformatf("reset_hold[%0d]", i), 1'b0, 3'd0);
    end
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Table: the first row also proves credit restarted from 0.
    for (int i = 0; i < 19; i++)
      step($sformatf("vec[%0d]", i), vecs[i].n, vecs[i].d, vecs[i].q,
           vecs[i].exp_soda, vecs[i].exp_change);

    // Four nickel edges with the strobe held high.
`ifdef VENDING_MACHINE_COIN_EDGE_EN
    step("nick_held[0]", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("nick_held[1]", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("nick_held[2]", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("nick_held[3]", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    // Only one nickel counted (credit 1); a 3-nickel top-up must vend 0.
    step("nick_gap",     1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step("nick_top_up",  1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
`else
    step("nick_held[0]", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("nick_held[1]", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("nick_held[2]", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step("nick_held[3]", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    step("nick_after",   1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
`endif

    // Quarter held three edges from credit 0.
    step("qtr_held[0]", 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
`ifdef VENDING_MACHINE_COIN_EDGE_EN
    step("qtr_held[1]", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    step("qtr_held[2]", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
`else
    step("qtr_held[1]", 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
    step("qtr_held[2]", 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
`endif
    step("qtr_release", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset during a soda cycle clears outputs at once.
    step("async_pre_d", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    step("async_pre_q", 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_clear", 1'b0, 3'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-accumulation discards credit: dime, reset, dime must not vend.
    step("discard_d0", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    pulse_reset();
    step("discard_d1", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    step("discard_gap", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step("discard_q",  1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
    step("discard_end", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_vending_machine
